// File: rtl/spi_flash_if.sv
// spi_flash_if: SPI pin bundle plus the synchronous read-only memory port
// used by spi_flash_responder.
//   slave modport  : the responder (samples SPI pins, drives MISO, issues reads)
//   master modport : the SPI controller / memory side
//   spi_sck/spi_ss/spi_mosi : SPI mode-0 inputs (asynchronous to clk)
//   spi_miso/spi_miso_oe    : serial response and its output enable
//   mem_rd_en/mem_addr      : one-cycle read strobe and byte address
//   mem_rdata               : read data, valid one clk after mem_rd_en
//   busy                    : transaction in progress
interface spi_flash_if #(
    parameter int MEM_AW = 16
);
    logic              spi_sck;
    logic              spi_ss;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              mem_rd_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, mem_rdata,
        output spi_miso, spi_miso_oe, mem_rd_en, mem_addr, busy
    );

    modport master (
        output spi_sck, spi_ss, spi_mosi, mem_rdata,
        input  spi_miso, spi_miso_oe, mem_rd_en, mem_addr, busy
    );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: target end of a mode-0 SPI NOR flash link. Oversamples
// SCK/SS/MOSI on clk, decodes READ (0x03), RDID (0x9F) and RDSR (0x05), and
// streams response bytes MSB first, fetching READ data from a synchronous
// read-only memory port with one byte of prefetch.
//   clk   : system clock, at least 8x the SCK frequency
//   rst_n : asynchronous active-low reset
//   bus   : spi_flash_if slave modport (SPI pins, memory port, busy)
// MEM_AW must be at least 8 and at most 24.
module spi_flash_responder #(
    parameter int          MEM_AW     = 16,
    parameter logic [23:0] JEDEC_ID   = 24'h012018,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_flash_if.slave     bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SRC_MEM    = 2'd0,
        SRC_ID     = 2'd1,
        SRC_STATUS = 2'd2
    } src_e;

    localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    // synchronizer stages; index 2 is only used as the edge-detect reference
    logic [2:0]        sck_sync_r;
    logic [2:0]        ss_sync_r;
    logic [1:0]        mosi_sync_r;
    // fills with ones after reset; a falling SS is trusted only once all
    // synchronizer stages hold real pin samples rather than reset values
    logic [2:0]        warm_r;

    logic              sck_rise_s, sck_fall_s, ss_rise_s, ss_fall_s, mosi_s;

    state_e            state_r, state_s;
    src_e              src_r, src_s;
    logic [4:0]        cnt_r, cnt_s;
    logic [2:0]        fcnt_r, fcnt_s;
    logic [MEM_AW-2:0] shin_r, shin_s;
    logic [MEM_AW-1:0] addr_r, addr_s, addr_inc_s, addr_full_s;
    logic [1:0]        id_idx_r, id_idx_s;
    logic [7:0]        tx_buf_r, tx_buf_s;
    logic [7:0]        tx_sh_r, tx_sh_s;
    logic [7:0]        cmd_byte_s;
    logic              miso_r, miso_s;
    logic              oe_r, oe_s;
    logic              rd_en_r, rd_en_s;
    logic [MEM_AW-1:0] mem_addr_r, mem_addr_s;
    logic              rd_pend_r, rd_pend_s;
    logic              busy_r, busy_s;

    // Two-flop synchronizers plus a third reference stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_r  <= 3'b000;
            ss_sync_r   <= 3'b111;
            mosi_sync_r <= 2'b00;
            warm_r      <= 3'b000;
        end else begin
            sck_sync_r  <= {sck_sync_r[1:0], bus.spi_sck};
            ss_sync_r   <= {ss_sync_r[1:0], bus.spi_ss};
            mosi_sync_r <= {mosi_sync_r[0], bus.spi_mosi};
            warm_r      <= {warm_r[1:0], 1'b1};
        end
    end

    assign sck_rise_s  = sck_sync_r[1] & ~sck_sync_r[2];
    assign sck_fall_s  = ~sck_sync_r[1] & sck_sync_r[2];
    assign ss_rise_s   = ss_sync_r[1] & ~ss_sync_r[2];
    assign ss_fall_s   = ~ss_sync_r[1] & ss_sync_r[2] & warm_r[2];
    assign mosi_s      = mosi_sync_r[1];
    assign cmd_byte_s  = {shin_r[6:0], mosi_s};
    // bits above MEM_AW have already fallen out of shin_r
    assign addr_full_s = {shin_r, mosi_s};
    assign addr_inc_s  = addr_r + ADDR_ONE;

    // Next-state and next-output logic for the command/address/data sequencer
    always_comb begin
        state_s    = state_r;
        src_s      = src_r;
        cnt_s      = cnt_r;
        fcnt_s     = fcnt_r;
        shin_s     = shin_r;
        addr_s     = addr_r;
        id_idx_s   = id_idx_r;
        tx_buf_s   = tx_buf_r;
        tx_sh_s    = tx_sh_r;
        miso_s     = miso_r;
        oe_s       = oe_r;
        rd_en_s    = 1'b0;
        mem_addr_s = mem_addr_r;
        rd_pend_s  = rd_en_r;
        busy_s     = busy_r;

        if (ss_rise_s) begin
            // deselect wins over any coincident SCK edge and drops in-flight reads
            state_s   = ST_IDLE;
            cnt_s     = 5'd0;
            fcnt_s    = 3'd0;
            shin_s    = '0;
            id_idx_s  = 2'd0;
            tx_buf_s  = 8'h00;
            tx_sh_s   = 8'h00;
            miso_s    = 1'b0;
            oe_s      = 1'b0;
            rd_pend_s = 1'b0;
            busy_s    = 1'b0;
        end else begin
            if (rd_pend_r) begin
                tx_buf_s = bus.mem_rdata;
            end else begin
                tx_buf_s = tx_buf_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        state_s = ST_CMD;
                        cnt_s   = 5'd0;
                        shin_s  = '0;
                        busy_s  = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sck_rise_s) begin
                        shin_s = {shin_r[MEM_AW-3:0], mosi_s};
                        if (cnt_r == 5'd7) begin
                            cnt_s  = 5'd0;
                            fcnt_s = 3'd0;
                            case (cmd_byte_s)
                                8'h03: state_s = ST_ADDR;
                                8'h9F: begin
                                    state_s  = ST_DATA;
                                    src_s    = SRC_ID;
                                    tx_buf_s = JEDEC_ID[23:16];
                                    id_idx_s = 2'd1;
                                end
                                8'h05: begin
                                    state_s  = ST_DATA;
                                    src_s    = SRC_STATUS;
                                    tx_buf_s = STATUS_VAL;
                                end
                                default: state_s = ST_IGNORE;
                            endcase
                        end else begin
                            cnt_s = cnt_r + 5'd1;
                        end
                    end else begin
                        shin_s = shin_r;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_s) begin
                        shin_s = {shin_r[MEM_AW-3:0], mosi_s};
                        if (cnt_r == 5'd23) begin
                            cnt_s      = 5'd0;
                            fcnt_s     = 3'd0;
                            addr_s     = addr_full_s;
                            mem_addr_s = addr_full_s;
                            rd_en_s    = 1'b1;
                            src_s      = SRC_MEM;
                            state_s    = ST_DATA;
                        end else begin
                            cnt_s = cnt_r + 5'd1;
                        end
                    end else begin
                        shin_s = shin_r;
                    end
                end
                ST_DATA: begin
                    if (sck_fall_s) begin
                        oe_s   = 1'b1;
                        fcnt_s = fcnt_r + 3'd1;
                        if (fcnt_r == 3'd0) begin
                            // first fall of a byte: the prefetched byte goes out
                            miso_s  = tx_buf_r[7];
                            tx_sh_s = {tx_buf_r[6:0], 1'b0};
                        end else begin
                            miso_s  = tx_sh_r[7];
                            tx_sh_s = {tx_sh_r[6:0], 1'b0};
                        end
                    end else if (sck_rise_s) begin
                        cnt_s = {2'b00, cnt_r[2:0] + 3'd1};
                        if (cnt_r[2:0] == 3'd7) begin
                            // last bit of this byte sampled: prepare the next one
                            case (src_r)
                                SRC_MEM: begin
                                    addr_s     = addr_inc_s;
                                    mem_addr_s = addr_inc_s;
                                    rd_en_s    = 1'b1;
                                end
                                SRC_ID: begin
                                    case (id_idx_r)
                                        2'd1: begin
                                            tx_buf_s = JEDEC_ID[15:8];
                                            id_idx_s = 2'd2;
                                        end
                                        2'd2: begin
                                            tx_buf_s = JEDEC_ID[7:0];
                                            id_idx_s = 2'd0;
                                        end
                                        default: begin
                                            tx_buf_s = JEDEC_ID[23:16];
                                            id_idx_s = 2'd1;
                                        end
                                    endcase
                                end
                                SRC_STATUS: tx_buf_s = STATUS_VAL;
                                default:    tx_buf_s = 8'h00;
                            endcase
                        end else begin
                            addr_s = addr_r;
                        end
                    end else begin
                        miso_s = miso_r;
                    end
                end
                ST_IGNORE: begin
                    oe_s   = 1'b0;
                    miso_s = 1'b0;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            src_r      <= SRC_MEM;
            cnt_r      <= 5'd0;
            fcnt_r     <= 3'd0;
            shin_r     <= '0;
            addr_r     <= '0;
            id_idx_r   <= 2'd0;
            tx_buf_r   <= 8'h00;
            tx_sh_r    <= 8'h00;
            miso_r     <= 1'b0;
            oe_r       <= 1'b0;
            rd_en_r    <= 1'b0;
            mem_addr_r <= '0;
            rd_pend_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            src_r      <= src_s;
            cnt_r      <= cnt_s;
            fcnt_r     <= fcnt_s;
            shin_r     <= shin_s;
            addr_r     <= addr_s;
            id_idx_r   <= id_idx_s;
            tx_buf_r   <= tx_buf_s;
            tx_sh_r    <= tx_sh_s;
            miso_r     <= miso_s;
            oe_r       <= oe_s;
            rd_en_r    <= rd_en_s;
            mem_addr_r <= mem_addr_s;
            rd_pend_r  <= rd_pend_s;
            busy_r     <= busy_s;
        end
    end

    assign bus.spi_miso    = miso_r;
    assign bus.spi_miso_oe = oe_r;
    assign bus.mem_rd_en   = rd_en_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: table-driven SPI transactions with a scoreboard of
// expected MISO bytes and expected memory read addresses, plus hand-written
// reset, abort and mid-transaction reset sequences.
module tb_spi_flash_responder;

    typedef struct {
        logic [7:0]        cmd;
        logic              send_addr;
        logic [23:0]       addr;
        int                nbytes;
        logic              ign;
        logic [0:4][7:0]   exp_data;
        int                n_rd;
        logic [0:4][15:0]  exp_rd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0]  rx_byte;
    logic        any_oe;
    logic        all_oe;
    logic [15:0] exp_rd_q[$];
    logic [7:0]  exp_byte_q[$];
    vec_t        vecs[7];
    int          ncyc;

    spi_flash_if #(.MEM_AW(16)) bus ();

    spi_flash_responder #(
        .MEM_AW(16),
        .JEDEC_ID(24'h012018),
        .STATUS_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // synchronous memory: data one clk after the strobe
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem_byte(bus.mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // read-address scoreboard
    always @(negedge clk) begin
        if (bus.mem_rd_en === 1'b1) begin
            if (exp_rd_q.size() == 0) begin
                check("unexpected_mem_rd", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                check("mem_rd_addr", 32'(bus.mem_addr), 32'(exp_rd_q.pop_front()));
            end
        end
    end

    function automatic vec_t mk(input logic [7:0] cmd, input logic send_addr,
                                input logic [23:0] addr, input int nbytes, input logic ign,
                                input logic [39:0] data, input int n_rd, input logic [79:0] rd);
        vec_t v;
        v.cmd = cmd; v.send_addr = send_addr; v.addr = addr; v.nbytes = nbytes;
        v.ign = ign; v.exp_data = data; v.n_rd = n_rd; v.exp_rd = rd;
        return v;
    endfunction

    // shift n bits MSB first; MISO sampled just before each rising SCK
    task automatic spi_bits(input logic [7:0] out, input int n);
        logic [7:0] sh;
        sh = out;
        rx_byte = 8'h00;
        any_oe = 1'b0;
        all_oe = 1'b1;
        for (int b = 0; b < n; b++) begin
            bus.spi_mosi = sh[7];
            sh = {sh[6:0], 1'b0};
            #80;
            rx_byte = {rx_byte[6:0], bus.spi_miso};
            any_oe = any_oe | bus.spi_miso_oe;
            all_oe = all_oe & bus.spi_miso_oe;
            bus.spi_sck = 1'b1;
            #80;
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic run_txn(input vec_t v);
        for (int i = 0; i < v.n_rd; i++) exp_rd_q.push_back(v.exp_rd[i]);
        if (!v.ign) for (int i = 0; i < v.nbytes; i++) exp_byte_q.push_back(v.exp_data[i]);
        bus.spi_ss = 1'b0;
        #80;
        spi_bits(v.cmd, 8);
        check("busy_in_txn", 32'(bus.busy), 32'd1);
        if (v.send_addr) begin
            spi_bits(v.addr[23:16], 8);
            spi_bits(v.addr[15:8], 8);
            spi_bits(v.addr[7:0], 8);
        end
        for (int i = 0; i < v.nbytes; i++) begin
            spi_bits(8'h00, 8);
            if (v.ign) begin
                check("oe_while_ignored", 32'(any_oe), 32'd0);
            end else begin
                check("oe_during_data", 32'(all_oe), 32'd1);
                if (exp_byte_q.size() == 0) check("byte_queue_empty", 32'(rx_byte), 32'hFFFF_FFFF);
                else check("miso_byte", 32'(rx_byte), 32'(exp_byte_q.pop_front()));
            end
        end
        bus.spi_ss = 1'b1;
        #60;
        check("oe_after_ss", 32'(bus.spi_miso_oe), 32'd0);
        check("miso_after_ss", 32'(bus.spi_miso), 32'd0);
        check("busy_after_ss", 32'(bus.busy), 32'd0);
        check("rd_left_over", 32'(exp_rd_q.size()), 32'd0);
        #100;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.spi_sck = 1'b0;
        bus.spi_ss = 1'b0;
        bus.spi_mosi = 1'b0;

        vecs[0] = mk(8'h03, 1'b1, 24'h000010, 4, 1'b0, 40'hB5B4B7B6_00, 5, 80'h0010_0011_0012_0013_0014);
        vecs[1] = mk(8'h03, 1'b1, 24'hABFFFF, 3, 1'b0, 40'hA5A5A4_0000, 4, 80'hFFFF_0000_0001_0002_0000);
        vecs[2] = mk(8'h9F, 1'b0, 24'h000000, 5, 1'b0, 40'h0120180120, 0, 80'h0);
        vecs[3] = mk(8'h05, 1'b0, 24'h000000, 2, 1'b0, 40'h0000_000000, 0, 80'h0);
        vecs[4] = mk(8'h42, 1'b0, 24'h000000, 2, 1'b1, 40'h0, 0, 80'h0);
        vecs[5] = mk(8'h03, 1'b1, 24'h000100, 2, 1'b0, 40'hA4A5_000000, 3, 80'h0100_0101_0102_0000_0000);
        vecs[6] = mk(8'h03, 1'b1, 24'h000002, 1, 1'b0, 40'hA7_00000000, 2, 80'h0002_0003_0000_0000_0000);

        // reset held with SS low and SCK toggling
        for (int i = 0; i < 6; i++) begin
            #40;
            bus.spi_sck = ~bus.spi_sck;
            #40;
            check("rst_miso", 32'(bus.spi_miso), 32'd0);
            check("rst_oe", 32'(bus.spi_miso_oe), 32'd0);
            check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
        end
        bus.spi_sck = 1'b0;
        #40;
        rst_n = 1'b1;
        #80;
        // SS already low at release: no transaction may start
        spi_bits(8'h9F, 8);
        spi_bits(8'h00, 8);
        check("no_start_ss_low_oe", 32'(any_oe), 32'd0);
        check("no_start_ss_low_busy", 32'(bus.busy), 32'd0);
        bus.spi_ss = 1'b1;
        #100;

        for (int t = 0; t < 6; t++) run_txn(vecs[t]);

        // abort after 12 address bits
        bus.spi_ss = 1'b0;
        #80;
        spi_bits(8'h03, 8);
        spi_bits(8'h00, 8);
        spi_bits(8'hF0, 4);
        bus.spi_ss = 1'b1;
        ncyc = 0;
        while (bus.busy === 1'b1 && ncyc < 8) begin
            @(negedge clk);
            ncyc++;
        end
        check("abort_busy_drop_clks_le4", 32'(ncyc <= 4), 32'd1);
        check("abort_oe", 32'(bus.spi_miso_oe), 32'd0);
        #100;
        run_txn(vecs[6]);

        // asynchronous reset in the middle of an RDID response
        bus.spi_ss = 1'b0;
        #80;
        spi_bits(8'h9F, 8);
        spi_bits(8'h00, 8);
        check("mid_rst_first_byte", 32'(rx_byte), 32'h01);
        bus.spi_mosi = 1'b0;
        #80;
        bus.spi_sck = 1'b1;
        #40;
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", 32'(bus.spi_miso), 32'd0);
        check("mid_rst_oe", 32'(bus.spi_miso_oe), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        #39;
        bus.spi_sck = 1'b0;
        #80;
        rst_n = 1'b1;
        #80;
        spi_bits(8'h05, 8);
        spi_bits(8'h00, 8);
        check("after_rst_ss_low_oe", 32'(any_oe), 32'd0);
        check("after_rst_ss_low_busy", 32'(bus.busy), 32'd0);
        bus.spi_ss = 1'b1;
        #100;
        run_txn(vecs[3]);
        run_txn(vecs[0]);

        check("byte_queue_drained", 32'(exp_byte_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
